// File: rtl/fetch_instr_queue_if.sv
// Bundle of the fetch-side push port and the decode-side pop port of the
// instruction queue. The producer/consumer side uses the master modport,
// the queue itself uses the slave modport.
//
// Handshake: a push slot transfers on a rising edge when in_valid_i selects
// it (legal masks 00/01/11) and in_ready_o is 1; in_ready_o is a
// conservative function of the current occupancy only. A head slot leaves
// the queue on a rising edge when out_valid_o marks it valid and pop_i
// selects it (legal masks 00/01/11); any other combination is a protocol
// violation that is ignored and reported on err_o one cycle later.
interface fetch_instr_queue_if #(
    parameter int PC_BITS    = 32,
    parameter int INSTR_BITS = 32
);
    logic [1:0]              in_valid_i;
    logic [2*PC_BITS-1:0]    in_pc_i;
    logic [2*INSTR_BITS-1:0] in_instr_i;
    logic [1:0]              in_taken_i;
    logic                    in_ready_o;
    logic [1:0]              out_valid_o;
    logic [2*PC_BITS-1:0]    out_pc_o;
    logic [2*INSTR_BITS-1:0] out_instr_o;
    logic [1:0]              out_taken_o;
    logic [1:0]              pop_i;

    modport master (
        output in_valid_i, in_pc_i, in_instr_i, in_taken_i, pop_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_taken_o
    );

    modport slave (
        input  in_valid_i, in_pc_i, in_instr_i, in_taken_i, pop_i,
        output in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_taken_o
    );
endinterface

// File: rtl/fetch_instr_queue.sv
// Two-wide in-order instruction queue between the fetch stage and decode.
// Circular buffer of DEPTH entries (PC, instruction word, predicted-taken),
// accepting up to two entries and releasing up to two entries per cycle.
// A flush drops every buffered entry. Protocol violations are ignored and
// pulse err_o for one cycle.
// Optional macro FIQ_BYPASS_EN: when the queue is empty, accepted entries
// appear on the outputs in the same cycle; entries popped that cycle are
// never written to the buffer.
module fetch_instr_queue #(
    parameter int PC_BITS    = 32,
    parameter int INSTR_BITS = 32,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    fetch_instr_queue_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  err_q, err_d;

    logic [PC_BITS-1:0]    pc_mem_q    [DEPTH];
    logic [PC_BITS-1:0]    pc_mem_d    [DEPTH];
    logic [INSTR_BITS-1:0] instr_mem_q [DEPTH];
    logic [INSTR_BITS-1:0] instr_mem_d [DEPTH];
    logic                  taken_mem_q [DEPTH];
    logic                  taken_mem_d [DEPTH];

    logic                  in_ready;
    logic                  push_legal;
    logic                  push_ok;
    logic                  push_err;
    logic [CNT_W-1:0]      push_n;
    logic                  bypass;
    logic [1:0]            vis_valid;
    logic [CNT_W-1:0]      pop_n;
    logic                  pop_err;
    logic [CNT_W-1:0]      skip_n;
    logic [PTR_W-1:0]      head_p1;

    // Ready depends only on the occupancy at the start of the cycle, so a
    // same-cycle pop never makes room for a push.
    assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign head_p1  = head_q + PTR_W'(1);

    // Classify the push request and how many entries it contributes.
    always_comb begin
        push_legal = (bus.in_valid_i == 2'b01) || (bus.in_valid_i == 2'b11);
        push_ok    = push_legal && in_ready;
        push_n     = '0;
        if (push_ok) begin
            push_n = bus.in_valid_i[1] ? CNT_W'(2) : CNT_W'(1);
        end
        push_err   = (bus.in_valid_i == 2'b10) || (push_legal && !in_ready);
    end

`ifdef FIQ_BYPASS_EN
    assign bypass = (count_q == '0) && !flush_i && push_ok;
`else
    assign bypass = 1'b0;
`endif

    // Head slots visible to decode: buffered entries, or the incoming ones
    // when they bypass an empty buffer.
    always_comb begin
        vis_valid = {(count_q >= CNT_W'(2)), (count_q != '0)};
        if (bypass) begin
            vis_valid = bus.in_valid_i;
        end
    end

    // Classify the pop request; an illegal pop is dropped as a whole.
    always_comb begin
        pop_n   = '0;
        pop_err = 1'b0;
        case (bus.pop_i)
            2'b00: ;
            2'b01: begin
                if (vis_valid[0]) pop_n = CNT_W'(1);
                else              pop_err = 1'b1;
            end
            2'b11: begin
                if (vis_valid[1]) pop_n = CNT_W'(2);
                else              pop_err = 1'b1;
            end
            default: pop_err = 1'b1;
        endcase
        // Bypassed entries consumed this cycle never touch the buffer.
        skip_n = bypass ? pop_n : '0;
    end

    // Drive the decode-side outputs from the buffer head or the bypass path.
    always_comb begin
        bus.in_ready_o  = in_ready;
        bus.out_valid_o = vis_valid;
        if (bypass) begin
            bus.out_pc_o    = bus.in_pc_i;
            bus.out_instr_o = bus.in_instr_i;
            bus.out_taken_o = bus.in_taken_i;
        end else begin
            bus.out_pc_o    = {pc_mem_q[head_p1], pc_mem_q[head_q]};
            bus.out_instr_o = {instr_mem_q[head_p1], instr_mem_q[head_q]};
            bus.out_taken_o = {taken_mem_q[head_p1], taken_mem_q[head_q]};
        end
    end

    // Next pointers, occupancy and error pulse; flush overrides everything.
    always_comb begin
        head_d  = head_q + pop_n[PTR_W-1:0] - skip_n[PTR_W-1:0];
        tail_d  = tail_q + push_n[PTR_W-1:0] - skip_n[PTR_W-1:0];
        count_d = count_q + push_n - pop_n;
        err_d   = push_err || pop_err;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end
    end

    // Write accepted, not-yet-consumed entries at the tail in slot order.
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        taken_mem_d = taken_mem_q;
        if (!flush_i) begin
            for (int s = 0; s < 2; s++) begin
                if ((CNT_W'(s) < push_n) && (CNT_W'(s) >= skip_n)) begin
                    pc_mem_d[tail_q + PTR_W'(s) - skip_n[PTR_W-1:0]] =
                        bus.in_pc_i[s*PC_BITS +: PC_BITS];
                    instr_mem_d[tail_q + PTR_W'(s) - skip_n[PTR_W-1:0]] =
                        bus.in_instr_i[s*INSTR_BITS +: INSTR_BITS];
                    taken_mem_d[tail_q + PTR_W'(s) - skip_n[PTR_W-1:0]] =
                        bus.in_taken_i[s];
                end
            end
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entry storage is never cleared; valid bits alone qualify its contents.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
        taken_mem_q <= taken_mem_d;
    end

    assign count_o = count_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_fetch_instr_queue.sv
// Testbench for fetch_instr_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model of the buffer.
module tb_fetch_instr_queue;
    localparam int PC_BITS    = 32;
    localparam int INSTR_BITS = 32;
    localparam int DEPTH      = 8;
    localparam int CW         = $clog2(DEPTH) + 1;
    localparam int ENT_W      = PC_BITS + INSTR_BITS + 1;
`ifdef FIQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i;
    logic [CW-1:0] count_o;
    logic          err_o;

    always #5 clk = ~clk;

    fetch_instr_queue_if #(.PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS)) bus();

    fetch_instr_queue #(
        .PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS), .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .bus     (bus),
        .count_o (count_o),
        .err_o   (err_o)
    );

    // ---------------- scoreboard state ----------------
    logic [ENT_W-1:0] exp_q[$];
    logic             err_exp = 1'b0;
    bit               chk_en  = 1'b0;
    int               checks  = 0;
    int               failures = 0;
    logic [31:0]      pc_ctr  = 32'h0;

    function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [ENT_W-1:0] in_ent(int s);
        return {bus.in_pc_i[s*PC_BITS +: PC_BITS],
                bus.in_instr_i[s*INSTR_BITS +: INSTR_BITS],
                bus.in_taken_i[s]};
    endfunction

    function automatic logic [ENT_W-1:0] out_ent(int s);
        return {bus.out_pc_o[s*PC_BITS +: PC_BITS],
                bus.out_instr_o[s*INSTR_BITS +: INSTR_BITS],
                bus.out_taken_o[s]};
    endfunction

    // Reference model: the queue content is a plain list of entries in
    // program order; the rules are applied to its size.
    always @(posedge clk) begin
        int  sz, npush, npop, vis;
        bit  ready, legal, perr, oerr;
        sz    = exp_q.size();
        ready = (sz <= DEPTH - 2);
        legal = (bus.in_valid_i == 2'b01) || (bus.in_valid_i == 2'b11);
        npush = (legal && ready) ? ((bus.in_valid_i == 2'b11) ? 2 : 1) : 0;
        perr  = (bus.in_valid_i == 2'b10) || (legal && !ready);
        vis   = (BYP && sz == 0 && !flush_i) ? npush : ((sz > 2) ? 2 : sz);
        npop  = 0;
        oerr  = 1'b0;
        case (bus.pop_i)
            2'b00: npop = 0;
            2'b01: if (vis >= 1) npop = 1; else oerr = 1'b1;
            2'b11: if (vis >= 2) npop = 2; else oerr = 1'b1;
            default: oerr = 1'b1;
        endcase
        if (!rst_n) begin
            exp_q.delete();
            err_exp = 1'b0;
            chk_en  = 1'b1;
        end else if (flush_i) begin
            exp_q.delete();
            err_exp = 1'b0;
        end else begin
            for (int s = 0; s < npush; s++) exp_q.push_back(in_ent(s));
            for (int k = 0; k < npop; k++) void'(exp_q.pop_front());
            err_exp = perr || oerr;
        end
    end

    // Monitor: mid-cycle, compare what the DUT presents with the model.
    always @(negedge clk) begin
        int               sz, nvis;
        logic [ENT_W-1:0] v0, v1;
        logic [1:0]       ov;
        #2;
        if (chk_en) begin
            sz = exp_q.size();
            v0 = '0;
            v1 = '0;
            if (BYP && sz == 0 && !flush_i &&
                (bus.in_valid_i == 2'b01 || bus.in_valid_i == 2'b11)) begin
                nvis = (bus.in_valid_i == 2'b11) ? 2 : 1;
                v0   = in_ent(0);
                v1   = in_ent(1);
            end else begin
                nvis = (sz > 2) ? 2 : sz;
                if (sz >= 1) v0 = exp_q[0];
                if (sz >= 2) v1 = exp_q[1];
            end
            ov = (nvis == 2) ? 2'b11 : ((nvis == 1) ? 2'b01 : 2'b00);
            check("count", 96'(count_o), 96'(sz));
            check("in_ready", 96'(bus.in_ready_o), 96'(sz <= DEPTH - 2));
            check("out_valid", 96'(bus.out_valid_o), 96'(ov));
            check("err", 96'(err_o), 96'(err_exp));
            if (nvis >= 1) check("head0", 96'(out_ent(0)), 96'(v0));
            if (nvis >= 2) check("head1", 96'(out_ent(1)), 96'(v1));
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic r, input logic f, input logic [1:0] v, input logic [1:0] p);
        @(negedge clk);
        rst_n          = r;
        flush_i        = f;
        bus.in_valid_i = v;
        bus.pop_i      = p;
        bus.in_pc_i    = {pc_ctr + 32'd4, pc_ctr};
        pc_ctr         = pc_ctr + 32'd8;
        bus.in_instr_i = {$urandom(), $urandom()};
        bus.in_taken_i = 2'($urandom_range(0, 3));
    endtask

    function automatic logic [1:0] pick_mask(int idle_w);
        int k;
        k = $urandom_range(0, 31);
        if (k == 0)          return 2'b10;
        else if (k <= idle_w) return 2'b00;
        else if (k <= 20)    return 2'b01;
        else                 return 2'b11;
    endfunction

    initial begin
        rst_n          = 1'b0;
        flush_i        = 1'b0;
        bus.in_valid_i = 2'b00;
        bus.pop_i      = 2'b00;
        bus.in_pc_i    = '0;
        bus.in_instr_i = '0;
        bus.in_taken_i = '0;

        // Reset then idle.
        cyc(0, 0, 2'b00, 2'b00);
        cyc(0, 0, 2'b00, 2'b00);
        cyc(1, 0, 2'b00, 2'b00);
        #3;
        check("rst_count", 96'(count_o), 96'(0));
        check("rst_out_valid", 96'(bus.out_valid_o), 96'(0));
        check("rst_in_ready", 96'(bus.in_ready_o), 96'(1));
        check("rst_err", 96'(err_o), 96'(0));

        // Two-wide push, visible next cycle.
        pc_ctr = 32'h100;
        cyc(1, 0, 2'b11, 2'b00);
        cyc(1, 0, 2'b00, 2'b00);
        #3;
        check("push2_count", 96'(count_o), 96'(2));
        check("push2_out_valid", 96'(bus.out_valid_o), 96'(3));
        check("push2_pc0", 96'(bus.out_pc_o[PC_BITS-1:0]), 96'(32'h100));
        check("push2_pc1", 96'(bus.out_pc_o[2*PC_BITS-1:PC_BITS]), 96'(32'h104));

        // Drain, then fill to DEPTH with four two-wide pushes.
        cyc(1, 0, 2'b00, 2'b11);
        repeat (4) cyc(1, 0, 2'b11, 2'b00);
        cyc(1, 0, 2'b00, 2'b00);
        #3;
        check("full_count", 96'(count_o), 96'(8));
        check("full_in_ready", 96'(bus.in_ready_o), 96'(0));

        // Push into a full queue: dropped, one-cycle error.
        cyc(1, 0, 2'b11, 2'b00);
        cyc(1, 0, 2'b00, 2'b00);
        #3;
        check("ovf_err", 96'(err_o), 96'(1));
        check("ovf_count", 96'(count_o), 96'(8));
        cyc(1, 0, 2'b00, 2'b00);
        #3;
        check("ovf_err_clear", 96'(err_o), 96'(0));

        // Steady push+pop at the highest accepting occupancy, across wrap.
        cyc(1, 0, 2'b00, 2'b11);
        repeat (8) cyc(1, 0, 2'b11, 2'b11);
        cyc(1, 0, 2'b00, 2'b00);
        #3;
        check("stream_count", 96'(count_o), 96'(6));
        check("stream_err", 96'(err_o), 96'(0));

        // Flush beats same-cycle push and pop at count 5.
        cyc(1, 0, 2'b00, 2'b01);
        cyc(1, 1, 2'b11, 2'b11);
        cyc(1, 0, 2'b00, 2'b00);
        #3;
        check("flush_count", 96'(count_o), 96'(0));
        check("flush_out_valid", 96'(bus.out_valid_o), 96'(0));
        check("flush_err", 96'(err_o), 96'(0));

        // Two-wide pop with a single entry: ignored, error.
        cyc(1, 0, 2'b01, 2'b00);
        cyc(1, 0, 2'b00, 2'b11);
        cyc(1, 0, 2'b00, 2'b00);
        #3;
        check("underpop_count", 96'(count_o), 96'(1));
        check("underpop_err", 96'(err_o), 96'(1));

`ifdef FIQ_BYPASS_EN
        // Zero-latency pass-through on an empty queue.
        cyc(1, 1, 2'b00, 2'b00);
        pc_ctr = 32'h200;
        cyc(1, 0, 2'b01, 2'b01);
        #3;
        check("byp_pc0", 96'(bus.out_pc_o[PC_BITS-1:0]), 96'(32'h200));
        check("byp_out_valid", 96'(bus.out_valid_o), 96'(1));
        cyc(1, 0, 2'b00, 2'b00);
        #3;
        check("byp_count", 96'(count_o), 96'(0));
        check("byp_err", 96'(err_o), 96'(0));
`endif

        // Random traffic, alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            logic r, f;
            int   ph;
            ph = (i / 150) % 2;
            r  = ($urandom_range(0, 499) != 0);
            f  = ($urandom_range(0, 59) == 0);
            cyc(r, f, pick_mask(ph ? 12 : 4), pick_mask(ph ? 4 : 12));
        end

        cyc(1, 0, 2'b00, 2'b00);
        @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
